// File: rtl/mips_pkg.sv
// mips_pkg: opcode class constants and stall controller state encoding.
package mips_pkg;
    localparam logic [5:0] OP_HLT     = 6'b010001;
    localparam logic [5:0] OP_LD      = 6'b010100;
    localparam logic [5:0] JUMP_MASK  = 6'b111100;
    localparam logic [5:0] JUMP_MATCH = 6'b011100;
    typedef enum logic [1:0] {S_IDLE, S_WIN, S_HALTED, S_RELEASE} state_t;
endpackage

// File: rtl/param_stall_controller_if.sv
// param_stall_controller_if: decode-side opcode/resume inputs and stall outputs.
interface param_stall_controller_if #(parameter int OP_W = 6);
    logic [OP_W-1:0] op;
    logic            resume;
    logic            stall;
    logic            stall_pm;
    logic            flush;
    logic            halted;
    modport master(output op, resume, input stall, stall_pm, flush, halted);
    modport slave(input op, resume, output stall, stall_pm, flush, halted);
endinterface

// File: rtl/op_class_decode.sv
// op_class_decode: classifies a 6-bit opcode as halt, load or jump.
module op_class_decode
    import mips_pkg::*;
(
    input  logic [5:0] op,
    output logic       is_hlt,
    output logic       is_ld,
    output logic       is_jump
);
    assign is_hlt  = op == OP_HLT;
    assign is_ld   = op == OP_LD;
    assign is_jump = (op & JUMP_MASK) == JUMP_MATCH;
endmodule

// File: rtl/param_stall_controller.sv
// param_stall_controller: holds the front end stalled for N cycles on loads/jumps
// and indefinitely on HLT until resume; registered stall copy for program memory.
module param_stall_controller
    import mips_pkg::*;
#(
    parameter int OP_W       = 6,
    parameter int LOAD_STALL = 1,
    parameter int JUMP_STALL = 2,
    parameter int CNT_W      = 4
) (
    input logic clk,
    input logic reset,
    param_stall_controller_if.slave bus
);
    localparam int MAX_N = (LOAD_STALL > JUMP_STALL) ? LOAD_STALL : JUMP_STALL;
    if (OP_W < 6) begin : g_bad_op_w
        $error("OP_W must be at least 6");
    end
    if (LOAD_STALL < 1 || LOAD_STALL > 15 || JUMP_STALL < 1 || JUMP_STALL > 15) begin : g_bad_stall
        $error("LOAD_STALL and JUMP_STALL must be in 1..15");
    end
    if (CNT_W < 1 || CNT_W > 31 || (MAX_N - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for the longest stall window");
    end
    localparam logic [CNT_W-1:0] LD_CNT  = CNT_W'(LOAD_STALL - 1);
    localparam logic [CNT_W-1:0] JP_CNT  = CNT_W'(JUMP_STALL - 1);
    localparam state_t           LD_NEXT = (LOAD_STALL == 1) ? S_RELEASE : S_WIN;
    localparam state_t           JP_NEXT = (JUMP_STALL == 1) ? S_RELEASE : S_WIN;
    state_t           state, next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             is_hlt, is_ld, is_jump;
    logic             stall_pm_q, halted_q;
    op_class_decode u_dec (
        .op     (bus.op[5:0]),
        .is_hlt (is_hlt),
        .is_ld  (is_ld),
        .is_jump(is_jump)
    );
    always_comb begin
        next     = state;
        cnt_next = cnt;
        case (state)
            S_IDLE: begin
                next     = is_hlt ? S_HALTED : is_ld ? LD_NEXT : is_jump ? JP_NEXT : S_IDLE;
                cnt_next = is_hlt ? cnt : is_ld ? LD_CNT : is_jump ? JP_CNT : cnt;
            end
            S_WIN: begin
                next     = (cnt == CNT_W'(1)) ? S_RELEASE : S_WIN;
                cnt_next = cnt - CNT_W'(1);
            end
            S_HALTED: next = bus.resume ? S_RELEASE : S_HALTED;
            default:  next = S_IDLE;
        endcase
    end
    // RELEASE deliberately drops stall without decoding so the held op advances once.
    assign bus.stall = !reset && (state == S_WIN || state == S_HALTED ||
                                  (state == S_IDLE && (is_hlt || is_ld || is_jump)));
    assign bus.flush = !reset && state == S_IDLE && is_jump && !is_hlt && !is_ld;
    assign bus.stall_pm = stall_pm_q;
    assign bus.halted   = halted_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            stall_pm_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state      <= next;
            cnt        <= cnt_next;
            stall_pm_q <= bus.stall;
            halted_q   <= next == S_HALTED;
        end
    end
endmodule

// File: tb/tb_param_stall_controller.sv
// tb_param_stall_controller: three parameter sets driven by shared random stimulus,
// each scored against a cycle-arithmetic model through an expectation queue.
module tb_param_stall_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       resume = 1'b0;
    logic [5:0] op = 6'd0;
    int         checks = 0;
    int         fails = 0;
    event       issued;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int LS = (k == 0) ? 1 : (k == 1) ? 4 : 15;
        localparam int JS = (k == 0) ? 2 : (k == 1) ? 3 : 1;
        param_stall_controller_if #(.OP_W(6)) bi ();
        assign bi.op     = op;
        assign bi.resume = resume;
        param_stall_controller #(.OP_W(6), .LOAD_STALL(LS), .JUMP_STALL(JS), .CNT_W(4)) dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bi)
        );
        // Model: absolute cycle numbers; stall holds while t < rel, t == rel is the release cycle.
        int         t = 0;
        int         rel = -1;
        bit         hlt_on = 1'b0;
        bit         prev = 1'b0;
        logic [3:0] q[$];
        always @(issued) begin
            logic s, f, h, pm;
            s = 1'b0; f = 1'b0; h = hlt_on; pm = prev;
            if (reset) begin
                h = 1'b0; pm = 1'b0; rel = t - 1; hlt_on = 1'b0;
            end else if (hlt_on) begin
                s = 1'b1;
                if (resume) begin hlt_on = 1'b0; rel = t + 1; end
            end else if (t < rel) s = 1'b1;
            else if (t == rel) s = 1'b0;
            else if (op == 6'b010001) begin s = 1'b1; hlt_on = 1'b1; end
            else if (op == 6'b010100) begin s = 1'b1; rel = t + LS; end
            else if (op[5:2] == 4'b0111) begin s = 1'b1; f = 1'b1; rel = t + JS; end
            prev = s;
            t++;
            q.push_back({s, f, pm, h});
        end
        always @(negedge clk) begin
            if (q.size() > 0) begin
                logic [3:0] e;
                e = q.pop_front();
                check($sformatf("i%0d_stall", k),    bi.stall,    e[3]);
                check($sformatf("i%0d_flush", k),    bi.flush,    e[2]);
                check($sformatf("i%0d_stall_pm", k), bi.stall_pm, e[1]);
                check($sformatf("i%0d_halted", k),   bi.halted,   e[0]);
            end
        end
    end

    task automatic drive(input bit r, input bit res, input logic [5:0] o);
        @(posedge clk);
        #1;
        reset = r;
        resume = res;
        op = o;
        ->issued;
    endtask

    // {reset, resume, op}
    logic [7:0] dir[] = '{
        8'h14, 8'h14, 8'h14, 8'h00, 8'h1d, 8'h1d, 8'h1d, 8'h1d, 8'h1d, 8'h1d,
        8'h40, 8'h11, 8'h11, 8'h11, 8'h11, 8'h51, 8'h00, 8'h00, 8'h40, 8'h14,
        8'h14, 8'h54, 8'h94, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h00, 8'h11,
        8'h40, 8'h40, 8'h80, 8'h14, 8'h00, 8'h00
    };

    initial begin
        logic [5:0] cur;
        cur = 6'd0;
        repeat (2) @(posedge clk);
        foreach (dir[i]) drive(dir[i][7], dir[i][6], dir[i][5:0]);
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 0)
                cur = (r < 2) ? 6'b010100 : (r < 4) ? {4'b0111, 2'($urandom_range(0, 3))} :
                      (r == 4) ? 6'b010001 : 6'($urandom_range(0, 63));
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, cur);
        end
        @(negedge clk);
        #1;
        check("sb_drain0", g_dut[0].q.size() == 0, 1'b1);
        check("sb_drain1", g_dut[1].q.size() == 0, 1'b1);
        check("sb_drain2", g_dut[2].q.size() == 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/param_stall_controller.md
# param_stall_controller

Parametrised successor to the single-cycle stall decoder in the MIPS pipeline. It sits between the instruction decode stage and the program-memory/PC logic. It decodes the opcode held in decode and holds the front end stalled for a configurable number of cycles on loads and jumps. It latches HLT until an external resume, and provides a registered stall copy for program memory plus a jump-flush pulse.

## Interface
Parameters:
- `OP_W`, 6: opcode width; class decodes use bits [5:0], and `OP_W` must be ≥ 6.
- `LOAD_STALL`, 1: stall cycles for a load (LD), range 1..15.
- `JUMP_STALL`, 2: stall cycles for a jump, range 1..15.
- `CNT_W`, 4: width of the window counter; must hold max(LOAD_STALL, JUMP_STALL)-1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `op`  in  OP_W  opcode of the instruction currently in decode.
- `resume`  in  1  leave HALTED; level-sampled on `clk`.
- `stall`  out  1  combinational stall to PC/IF/ID registers.
- `stall_pm`  out  1  `stall` registered by one cycle, for program memory.
- `flush`  out  1  one-cycle pulse on the first cycle of a jump window.
- `halted`  out  1  registered; 1 while in HALTED.

## Operation
- Class decode on `op[5:0]`:
  - HLT = 6'b010001.
  - LD = 6'b010100.
  - JUMP = op[5]==0 && op[4:2]==3'b111 (6'b0111xx).
  - Priority is HLT > LD > JUMP.
- FSM states: IDLE, WIN (stall window), HALTED, RELEASE. `cnt` is CNT_W bits.
- IDLE:
  - On HLT: `stall`=1 this cycle; next state HALTED.
  - On LD: `stall`=1; cnt←LOAD_STALL-1; next state WIN, or RELEASE if LOAD_STALL==1.
  - On JUMP: `stall`=1 and `flush`=1; cnt←JUMP_STALL-1; next state WIN, or RELEASE if JUMP_STALL==1.
  - Otherwise `stall`=0 and the state stays IDLE.
- WIN:
  - `stall`=1 and `op` is ignored.
  - cnt decrements each cycle. When cnt==1 at the edge, the next state is RELEASE.
  - Total stall length is exactly N consecutive cycles for the class's N.
- RELEASE:
  - `stall`=0 and decode is suppressed for this one cycle, so the held instruction advances and does not retrigger.
  - Next state IDLE.
- HALTED:
  - `stall`=1 and `op` is ignored.
  - When `resume`=1 at the edge, the next state is RELEASE.
  - `resume` in any other state has no effect.
- `stall_pm` ← `stall` every cycle.
- `halted` ← (next state == HALTED).
- `flush` is combinational and only asserted from IDLE.

## Timing
- Reset (asynchronous): state=IDLE, cnt=0, `stall_pm`=0, `halted`=0. During reset, `stall`=0 and `flush`=0.
- Reset during WIN or HALTED aborts the window. On the first edge after release, IDLE decode applies normally.
- Latency:
  - `stall` and `flush` appear in the same cycle `op` is presented (zero latency).
  - `stall_pm` lags `stall` by exactly 1 cycle.
  - `halted` rises 1 cycle after the HLT decode.
  - After `resume` is sampled, `stall` falls in the next cycle (RELEASE). It is at the earliest re-raised 2 cycles after `resume`.
- Back-to-back classes: a new LD/JUMP/HLT is accepted only in IDLE. The minimum spacing between window starts is N+1 cycles.
- Simultaneous LD and JUMP cannot occur, since the encodings are disjoint. HLT always wins priority.
- Out-of-range parameters must fail elaboration.

## Structure
- Shared package `mips_pkg`: opcode constants `OP_HLT`, `OP_LD`, JUMP mask/match, and the FSM state enum.
- One natural sub-module, `op_class_decode`: combinational `op` → {is_hlt, is_ld, is_jump}. It is reusable by the forwarding unit.
- FSM and counter live in the top module.

## Test plan
- Reset: assert `reset` mid-cycle with op=LD → `stall` and `stall_pm` go to 0 immediately. After release, LD restalls for LOAD_STALL cycles.
- LD, defaults: op=6'b010100 held → `stall`=1 for 1 cycle, then 0 (RELEASE). `stall_pm` is high 1 cycle later.
- JUMP with JUMP_STALL=3: op=6'b011101 held → `flush`=1 on cycle 0 only, `stall`=1 for cycles 0–2, 0 on cycle 3, and restall on cycle 4 if the op is still a jump.
- HLT/resume: op=6'b010001 → `stall`=1 indefinitely and `halted`=1 from the next cycle. `resume` pulse → `stall`=0 the next cycle, `halted` falls.
- Resume ignored: pulse `resume` in IDLE and in WIN → no change to state, cnt or outputs.
- Parameter sweep: LOAD_STALL ∈ {1, 4, 15} → the stall run length equals the parameter exactly, with no retrigger in RELEASE.
